mem_responder: RTL

- Memory-side responder that serves aligned 64-bit word read/write requests over a valid/ready request channel and returns results on a valid/ready response channel.
- It is the target end of the aligned-word accesses that the core's memory access controller issues. That controller splits unaligned byte accesses into one or two 8-byte-aligned accesses, each with a 64-bit bit mask.
- Holds a register-array RAM of DEPTH words.
- Models a fixed, configurable access latency.

---
 rtl/mem_responder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: serves masked 64-bit word reads/writes after a fixed access latency.
// Build macro MEM_RESP_BYTE_ADDR_EN switches req_addr_i from word index to physical byte address.
module mem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned AW      = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wen_i,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_wdata_i,
    input  logic [63:0] req_wmask_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [63:0] resp_rdata_o,
    output logic        resp_err_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    localparam logic [3:0] LatInit = 4'(LATENCY - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        wen_q;
    logic [63:0] addr_q, wdata_q, wmask_q;

    logic [63:0] mem_q [DEPTH];

    logic        accept;
    logic        commit;
    logic        addr_err;
    logic [63:0] word_idx;
    logic [AW-1:0] idx;
    logic [63:0] cur_word;

`ifdef MEM_RESP_BYTE_ADDR_EN
    localparam logic [63:0] BaseAddr = 64'h0000_0000_8000_0000;
    logic [63:0] offset;

    assign offset   = addr_q - BaseAddr;
    assign word_idx = {3'b000, offset[63:3]};
    // Base is 8-byte aligned, so offset[2:0] equals the address alignment bits.
    assign addr_err = (offset[2:0] != 3'b000) || (addr_q < BaseAddr) ||
                      (word_idx >= 64'(DEPTH));
`else
    assign word_idx = addr_q;
    assign addr_err = (addr_q >= 64'(DEPTH));
`endif

    assign idx      = word_idx[AW-1:0];
    assign cur_word = mem_q[idx];

    assign accept = (state_q == StIdle) && req_valid_i;
    assign commit = (state_q == StBusy) && (cnt_q == 4'd0);

    assign req_ready_o  = (state_q == StIdle);
    assign resp_valid_o = (state_q == StResp);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    state_d = StBusy;
                    cnt_d   = LatInit;
                end
            end
            StBusy: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    rdata_d = addr_err ? 64'd0 : cur_word;
                    err_d   = addr_err;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (resp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q   <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            wmask_q <= 64'd0;
        end else if (accept) begin
            wen_q   <= req_wen_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            wmask_q <= req_wmask_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 64'd0;
            end
        end else if (commit && wen_q && !addr_err) begin
            mem_q[idx] <= (cur_word & ~wmask_q) | (wdata_q & wmask_q);
        end
    end

endmodule
